// File: rtl/spi_phase_sequencer.sv
// spi_phase_sequencer: starts N display engines in order and muxes the active engine's SPI lines.
// Optional build macro SEQ_LOOP_EN: after the last phase, loop back to LOOP_PHASE instead of stopping in FIN.
`default_nettype none

module spi_phase_sequencer #(
  parameter int N_PHASES   = 3,
  parameter int PW         = 4,
  parameter int TIMEOUT    = 0,
  parameter int AUTO_START = 1,
  parameter int LOOP_PHASE = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_go,
  input  logic [N_PHASES-1:0] i_skip,
  input  logic [N_PHASES-1:0] i_done,
  input  logic [N_PHASES-1:0] i_mosi,
  input  logic [N_PHASES-1:0] i_dc,
  input  logic [N_PHASES-1:0] i_cs,
  output logic [N_PHASES-1:0] o_start,
  output logic                o_mosi,
  output logic                o_dc,
  output logic                o_cs,
  output logic [PW-1:0]       o_phase,
  output logic                o_busy,
  output logic                o_fin,
  output logic                o_err,
  output logic [15:0]         o_frames
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [PW-1:0] LAST     = PW'(N_PHASES - 1);
  localparam logic [31:0]   WD_LIMIT = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
`ifdef SEQ_LOOP_EN
  localparam logic [PW-1:0] LOOP_IDX = PW'(LOOP_PHASE);
`endif

  if (N_PHASES < 1 || N_PHASES > 16 || (1 << PW) < N_PHASES ||
      LOOP_PHASE < 0 || LOOP_PHASE >= N_PHASES) begin : g_param_check
    $error("spi_phase_sequencer: illegal parameter combination");
  end

  state_t              state;
  logic [PW-1:0]       phase;
  logic [31:0]         wdog;
  logic [15:0]         frames;
  logic                auto_pend;

  logic                skip_cur;
  logic                done_cur;
  logic                mosi_cur;
  logic                dc_cur;
  logic                cs_cur;
  logic [N_PHASES-1:0] start_vec;
  logic                active;
  logic                seq_end;

  // Per-phase selection by compare so the index never exceeds the vector widths.
  always_comb begin
    skip_cur  = 1'b0;
    done_cur  = 1'b0;
    mosi_cur  = 1'b0;
    dc_cur    = 1'b0;
    cs_cur    = 1'b1;
    start_vec = '0;
    for (int k = 0; k < N_PHASES; k++) begin
      if (phase == PW'(k)) begin
        skip_cur     = i_skip[k];
        done_cur     = i_done[k];
        mosi_cur     = i_mosi[k];
        dc_cur       = i_dc[k];
        cs_cur       = i_cs[k];
        start_vec[k] = 1'b1;
      end
    end
  end

  assign seq_end = (phase == LAST) &&
                   (((state == S_SCAN) && skip_cur) || ((state == S_RUN) && done_cur));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      wdog      <= '0;
      frames    <= '0;
      auto_pend <= (AUTO_START != 0);
    end else if (seq_end) begin
      frames <= frames + 16'd1;
`ifdef SEQ_LOOP_EN
      phase  <= LOOP_IDX;
      state  <= S_SCAN;
`else
      state  <= S_FIN;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (auto_pend || i_go) begin
            auto_pend <= 1'b0;
            phase     <= '0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!skip_cur) begin
            state <= S_START;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          wdog <= wdog + 32'd1;
          if (done_cur) begin
            phase <= phase + PW'(1);
            state <= S_SCAN;
          end else if (TIMEOUT != 0 && wdog == WD_LIMIT) begin
            state <= S_ERR;
          end
        end
        S_FIN, S_ERR: begin
          if (i_go) begin
            phase <= '0;
            state <= S_SCAN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign active   = (state == S_START) || (state == S_RUN);
  assign o_start  = (state == S_START) ? start_vec : '0;
  assign o_mosi   = active & mosi_cur;
  assign o_dc     = active & dc_cur;
  assign o_cs     = active ? cs_cur : 1'b1;
  assign o_phase  = phase;
  assign o_busy   = (state == S_SCAN) || active;
  assign o_fin    = (state == S_FIN);
  assign o_err    = (state == S_ERR);
  assign o_frames = frames;

endmodule

`default_nettype wire

// File: tb/tb_spi_phase_sequencer.sv
// Bench for spi_phase_sequencer: a per-cycle expected timeline is planned from phase durations, then played and checked.
`default_nettype none

module tb_spi_phase_sequencer;
  localparam int N     = 3;
  localparam int PW    = 4;
  localparam int TMO   = 50;
  localparam int LOOPP = 1;
  localparam int MAXC  = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [N-1:0]  skip = '0, done = '0, mosi = '0, dc = '0, cs = '1;
  logic [N-1:0]  start;
  logic          omosi, odc, ocs, busy, fin, err;
  logic [PW-1:0] phase;
  logic [15:0]   frames;

  spi_phase_sequencer #(
    .N_PHASES(N), .PW(PW), .TIMEOUT(TMO), .AUTO_START(1), .LOOP_PHASE(LOOPP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_skip(skip), .i_done(done),
    .i_mosi(mosi), .i_dc(dc), .i_cs(cs), .o_start(start), .o_mosi(omosi),
    .o_dc(odc), .o_cs(ocs), .o_phase(phase), .o_busy(busy), .o_fin(fin),
    .o_err(err), .o_frames(frames)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int mf = 0, mphase = 0;

  // Expected timeline, one entry per clock cycle after reset release.
  int           e_start[MAXC], e_act[MAXC], e_done[MAXC], e_phase[MAXC];
  bit           e_busy[MAXC], e_fin[MAXC], e_err[MAXC], e_go[MAXC];
  logic [N-1:0] e_skip[MAXC];
  logic [15:0]  e_frames[MAXC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic put(input int c, input bit b, input bit f, input bit e, input int ph,
                     input logic [N-1:0] sk);
    e_busy[c] = b; e_fin[c] = f; e_err[c] = e; e_phase[c] = ph;
    e_frames[c] = 16'(mf);
    e_start[c] = -1; e_act[c] = -1; e_done[c] = -1; e_go[c] = 1'b0;
    e_skip[c] = b ? sk : N'($urandom);
  endtask

  // One pass from phase p0. gap[k] = cycles from engine k's start pulse to its done;
  // gap outside 1..TMO means the engine never answers and the watchdog fires.
  task automatic plan_pass(inout int t, input int p0, input logic [N-1:0] sk,
                           input int gap[N], output bit failed);
    failed = 1'b0;
    for (int k = p0; k < N; k++) begin
      put(t, 1, 0, 0, k, sk);
      if (sk[k]) begin
        t++;
        continue;
      end
      put(t + 1, 1, 0, 0, k, sk);
      e_start[t + 1] = k; e_act[t + 1] = k;
      if (gap[k] < 1 || gap[k] > TMO) begin
        for (int r = 0; r < TMO; r++) begin
          put(t + 2 + r, 1, 0, 0, k, sk); e_act[t + 2 + r] = k;
        end
        t = t + 2 + TMO; mphase = k; failed = 1'b1;
        return;
      end
      for (int r = 0; r < gap[k]; r++) begin
        put(t + 2 + r, 1, 0, 0, k, sk); e_act[t + 2 + r] = k;
      end
      e_done[t + 1 + gap[k]] = k;
      t = t + 2 + gap[k];
    end
    mf = (mf + 1) & 16'hFFFF;
    mphase = N - 1;
  endtask

  task automatic plan_hold(inout int t, input int n, input bit f, input bit e, input bit go_last);
    for (int r = 0; r < n; r++) begin
      put(t, 0, f, e, mphase, '0);
      t++;
    end
    if (go_last) begin
      e_go[t - 1] = 1'b1;
      mphase = 0;
    end
  endtask

  task automatic play_cycle(input int c);
    logic [N-1:0] d, es;
    logic         xm, xd, xc;
    cyc  = c;
    skip = e_skip[c];
    mosi = N'($urandom); dc = N'($urandom); cs = N'($urandom);
    d = N'($urandom);
    if (e_act[c] >= 0 && e_start[c] < 0) d[e_act[c]] = (e_done[c] == e_act[c]);
    done = d;
    go = e_busy[c] ? 1'($urandom) : e_go[c];
    #1;
    es = '0;
    if (e_start[c] >= 0) es[e_start[c]] = 1'b1;
    xm = 1'b0; xd = 1'b0; xc = 1'b1;
    if (e_act[c] >= 0) begin
      xm = mosi[e_act[c]]; xd = dc[e_act[c]]; xc = cs[e_act[c]];
    end
    check("start",  32'(start),  32'(es));
    check("mosi",   32'(omosi),  32'(xm));
    check("dc",     32'(odc),    32'(xd));
    check("cs",     32'(ocs),    32'(xc));
    check("busy",   32'(busy),   32'(e_busy[c]));
    check("fin",    32'(fin),    32'(e_fin[c]));
    check("err",    32'(err),    32'(e_err[c]));
    check("phase",  32'(phase),  32'(e_phase[c]));
    check("frames", 32'(frames), 32'(e_frames[c]));
  endtask

  task automatic play(input int a, input int b);
    for (int c = a; c <= b; c++) begin
      @(posedge clk); #1;
      play_cycle(c);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_start"},  32'(start),  32'd0);
    check({tag, "_mosi"},   32'(omosi),  32'd0);
    check({tag, "_dc"},     32'(odc),    32'd0);
    check({tag, "_cs"},     32'(ocs),    32'd1);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_fin"},    32'(fin),    32'd0);
    check({tag, "_err"},    32'(err),    32'd0);
    check({tag, "_phase"},  32'(phase),  32'd0);
    check({tag, "_frames"}, 32'(frames), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    mf = 0; mphase = 0;
    put(0, 0, 0, 0, 0, '0);
    play_cycle(0);
  endtask

  task automatic rand_gaps(output int g[N]);
    for (int k = 0; k < N; k++)
      g[k] = ($urandom_range(0, 4) == 0) ? TMO : int'($urandom_range(1, 20));
  endtask

  initial begin
    int  t, rc, s;
    int  g[N];
    bit  failed;
    logic [N-1:0] sk;

    // Reset held with random inputs.
    mosi = N'($urandom); dc = N'($urandom); cs = N'($urandom); go = 1'b1; done = '1;
    #3 check_reset("rst0");
    repeat (3) begin
      @(posedge clk); #1;
      check_reset("rst_hold");
    end
    release_reset();
    t = 1;

`ifdef SEQ_LOOP_EN
    g = '{10, 10, 10};
    plan_pass(t, 0, '0, g, failed);
    for (int p = 0; p < 4; p++) begin
      rand_gaps(g);
      sk = N'($urandom);
      plan_pass(t, LOOPP, sk, g, failed);
    end
    play(1, t - 1);
`else
    g = '{10, 10, 10};
    plan_pass(t, 0, '0, g, failed);
    plan_hold(t, 5, 1, 0, 1);
    plan_pass(t, 0, 3'b010, g, failed);
    plan_hold(t, 3, 1, 0, 1);
    plan_pass(t, 0, '1, g, failed);
    plan_hold(t, 2, 1, 0, 1);
    for (int p = 0; p < 5; p++) begin
      rand_gaps(g);
      sk = N'($urandom);
      plan_pass(t, 0, sk, g, failed);
      plan_hold(t, int'($urandom_range(1, 4)), 1, 0, 1);
    end
    // Engine 1 never answers: watchdog error, then restart by i_go.
    g = '{int'($urandom_range(1, 20)), -1, 10};
    plan_pass(t, 0, '0, g, failed);
    plan_hold(t, 4, 0, 1, 1);
    // Done lands on the watchdog's last cycle while i_go toggles randomly.
    g = '{5, TMO, 3};
    plan_pass(t, 0, '0, g, failed);
    plan_hold(t, 2, 1, 0, 1);
    // Reset will hit during RUN of phase 1.
    s = t;
    g = '{3, 40, 3};
    plan_pass(t, 0, '0, g, failed);
    rc = s + 10;
    play(1, rc - 1);

    @(posedge clk); #1;
    cyc = rc;
    rst = 1'b0;
    #1 check_reset("rst_mid");
    repeat (2) @(posedge clk);
    release_reset();
    t = 1;
    plan_pass(t, 0, '1, g, failed);
    plan_hold(t, 2, 1, 0, 1);
    rand_gaps(g);
    sk = N'($urandom);
    plan_pass(t, 0, sk, g, failed);
    plan_hold(t, 3, 1, 0, 0);
    play(1, t - 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
